// File: rtl/button_conditioner.sv
// button_conditioner: per-button 2-FF sync, debounce and one-clock press pulse.
// Define AUTO_REPEAT_EN to add auto-repeat pulses on held buttons in REPEAT_MASK.
module button_conditioner #(
   parameter int          N_BTN           = 5,
   parameter int          DEBOUNCE_CYCLES = 16,
   parameter int          REPEAT_DELAY    = 8,
   parameter int          REPEAT_PERIOD   = 4,
   parameter int unsigned REPEAT_MASK     = 5'b01111
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [N_BTN-1:0] BtnRaw,
   output logic [N_BTN-1:0] BtnLevel,
   output logic [N_BTN-1:0] BtnPulse
);

   localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                          DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
   localparam int CW    = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam int S_IDLE  = 0;
   localparam int S_PRESS = 1;
   localparam int S_PULSE = 2;
   localparam int S_HELD  = 3;
   localparam int S_REL   = 4;

   typedef enum logic [4:0] {
      IDLE       = 5'b00001,
      PRESS_WAIT = 5'b00010,
      PULSE      = 5'b00100,
      HELD       = 5'b01000,
      REL_WAIT   = 5'b10000
   } state_t;

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be at least 2");
   end
   if ((64'(REPEAT_MASK) >> N_BTN) != 64'd0) begin : g_bad_mask
      $error("REPEAT_MASK has bits beyond N_BTN");
   end

   logic [N_BTN-1:0] s1;
   logic [N_BTN-1:0] s2;
   logic [N_BTN-1:0] level_d;
   logic [N_BTN-1:0] pulse_d;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         s1       <= '0;
         s2       <= '0;
         BtnLevel <= '0;
         BtnPulse <= '0;
      end else begin
         s1       <= BtnRaw;
         s2       <= s1;
         BtnLevel <= level_d;
         BtnPulse <= pulse_d;
      end
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      state_t        st;
      state_t        st_nx;
      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nx;
      logic          rep_fire;

      always_ff @(posedge Clk or negedge Reset) begin
         if (!Reset) begin
            st  <= IDLE;
            cnt <= '0;
         end else begin
            st  <= st_nx;
            cnt <= cnt_nx;
         end
      end

      always_comb begin
         st_nx  = st;
         cnt_nx = cnt;
         unique case (1'b1)
            st[S_IDLE]: begin
               cnt_nx = '0;
               if (s2[i]) begin
                  st_nx  = PRESS_WAIT;
                  cnt_nx = CW'(1);
               end
            end
            st[S_PRESS]: begin
               if (!s2[i]) begin
                  st_nx  = IDLE;
                  cnt_nx = '0;
               end else if (cnt == DB_LAST) begin
                  st_nx  = PULSE;
                  cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            st[S_PULSE]: begin
               st_nx  = HELD;
               cnt_nx = '0;
            end
            st[S_HELD]: begin
               if (!s2[i]) begin
                  st_nx  = REL_WAIT;
                  cnt_nx = CW'(1);
               end
            end
            st[S_REL]: begin
               if (s2[i]) begin
                  st_nx  = HELD;
                  cnt_nx = '0;
               end else if (cnt == DB_LAST) begin
                  st_nx  = IDLE;
                  cnt_nx = '0;
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            default: begin
               st_nx  = IDLE;
               cnt_nx = '0;
            end
         endcase
      end

      assign level_d[i] = st[S_PULSE] | st[S_HELD] | st[S_REL];
      assign pulse_d[i] = st[S_PULSE] | rep_fire;

`ifdef AUTO_REPEAT_EN
      if (((REPEAT_MASK >> i) & 1) != 0) begin : g_rep
         logic [CW-1:0] rcnt;
         logic [CW-1:0] rep_last;
         logic          rep_armed;

         // First repeat waits the long delay, later ones the short period
         assign rep_last = rep_armed ? CW'(REPEAT_PERIOD - 1) :
                                       CW'(REPEAT_DELAY - 1);
         assign rep_fire = st[S_HELD] && (rcnt == rep_last);

         always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
               rcnt      <= '0;
               rep_armed <= 1'b0;
            end else if (st[S_PULSE]) begin
               rcnt      <= '0;
               rep_armed <= 1'b0;
            end else if (rep_fire) begin
               rcnt      <= '0;
               rep_armed <= 1'b1;
            end else if (st[S_HELD]) begin
               rcnt      <= rcnt + CW'(1);
            end
         end
      end else begin : g_no_rep
         assign rep_fire = 1'b0;
      end
`else
      assign rep_fire = 1'b0;
`endif
   end

endmodule
